// File: rtl/vote_pkg.sv
// Shared constants for the vote frame collector: FSM encoding, vote word width
// and the default frame-counter width.
package vote_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    localparam int VOTE_W      = 3;
    localparam int FRAME_W_DEF = 8;

endpackage : vote_pkg

// File: rtl/vote_frame_collector_if.sv
// Serial vote input and assembled-frame output bundle. The master drives the
// serial side; the slave is the collector itself.
interface vote_frame_collector_if
    import vote_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF
);
    logic               start;
    logic               bit_in;
    logic               bit_vld;
    logic [VOTE_W-1:0]  a;
    logic               en;
    logic               busy;
    logic [FRAME_W-1:0] frame_cnt;
    logic               err;

    modport master (
        output start, bit_in, bit_vld,
        input  a, en, busy, frame_cnt, err
    );

    modport slave (
        input  start, bit_in, bit_vld,
        output a, en, busy, frame_cnt, err
    );
endinterface : vote_frame_collector_if

// File: rtl/wrap_counter.sv
// Free-running wrap-around counter with synchronous reset, clear and
// increment enable; clear wins over increment.
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear, increment or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule : wrap_counter

// File: rtl/vote_frame_collector.sv
// Shifts in three serial vote bits (MSB first) and presents the word on a
// with a registered en strobe held for HOLD_CYCLES; counts frames, flags errors.
module vote_frame_collector
    import vote_pkg::*;
#(
    parameter int FRAME_W     = FRAME_W_DEF,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    vote_frame_collector_if.slave  bus
);
    localparam int                 HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        state_d, state_q;
    // Only the two oldest bits need storing; the third arrives with bit_in.
    logic [1:0]        sr_d, sr_q;
    logic [1:0]        idx_d, idx_q;
    logic [VOTE_W-1:0] a_d, a_q;
    logic              en_d, en_q;
    logic              busy_d, busy_q;
    logic              err_d, err_q;

    logic              frame_inc_s;
    logic              hold_inc_s;
    logic              hold_clr_s;
    logic [HOLD_W-1:0] hold_cnt_s;

    wrap_counter #(.W(FRAME_W)) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (frame_inc_s),
        .cnt (bus.frame_cnt)
    );

    wrap_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hold_clr_s),
        .inc (hold_inc_s),
        .cnt (hold_cnt_s)
    );

    // Frame FSM: collect three bits, present the word, flag protocol errors.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        idx_d       = idx_q;
        a_d         = a_q;
        err_d       = err_q;
        frame_inc_s = 1'b0;
        hold_inc_s  = 1'b0;
        hold_clr_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_COLLECT;
                    sr_d    = 2'b00;
                    idx_d   = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (bus.start) begin
                    err_d = 1'b1;
                    if (bus.bit_vld) begin
                        sr_d  = {1'b0, bus.bit_in};
                        idx_d = 2'd1;
                    end else begin
                        sr_d  = 2'b00;
                        idx_d = 2'd0;
                    end
                end else if (bus.bit_vld) begin
                    if (idx_q == 2'd2) begin
                        a_d         = {sr_q, bus.bit_in};
                        state_d     = ST_PRESENT;
                        idx_d       = 2'd0;
                        frame_inc_s = 1'b1;
                    end else begin
                        sr_d  = {sr_q[0], bus.bit_in};
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_PRESENT: begin
                if (bus.start || bus.bit_vld) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (hold_cnt_s == HOLD_LAST) begin
                    state_d    = ST_IDLE;
                    hold_clr_s = 1'b1;
                end else begin
                    hold_inc_s = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_clr_s = 1'b1;
            end
        endcase
        en_d   = (state_d == ST_PRESENT);
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= 2'b00;
            idx_q   <= 2'd0;
            a_q     <= 3'b000;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.en   = en_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
endmodule : vote_frame_collector

// File: tb/tb_vote_frame_collector.sv
// Scoreboard bench: two collectors (default, and FRAME_W=2/HOLD_CYCLES=3) share
// stimulus; a frame-level reference model feeds queues checked by a monitor.
module tb_vote_frame_collector;
    import vote_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vote_frame_collector_if                if0 ();
    vote_frame_collector_if #(.FRAME_W(2)) if1 ();

    vote_frame_collector u0 (.clk(clk), .rst(rst), .bus(if0));
    vote_frame_collector #(.FRAME_W(2), .HOLD_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct packed {
        logic       busy;
        logic       en;
        logic       err;
        logic [2:0] a;
        logic [7:0] cnt;
    } stat_t;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] cnt;
        logic       f;
    } frm_t;

    stat_t sq0[$], sq1[$];
    frm_t  fq0[$], fq1[$];

    int tests = 0;
    int fails = 0;

    // Reference model state: mode 0=idle 1=collecting 2=presenting
    int m_mode[2], m_nb[2], m_val[2], m_hold[2], m_a[2], m_cnt[2], m_err[2], m_frames[2];
    int hc[2] = '{1, 3};
    int fw[2] = '{8, 2};

    int  run[2], pulses[2];
    logic prev_en[2] = '{1'b0, 1'b0};

    function automatic logic majority(input int v);
        return (((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)) >= 2;
    endfunction

    task automatic model_step(input int i, input bit r, input bit s, input bit v, input bit b);
        stat_t se;
        frm_t  fe;
        if (r) begin
            m_mode[i] = 0; m_nb[i] = 0; m_val[i] = 0;
            m_a[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
        end else begin
            case (m_mode[i])
                0: if (s) begin m_mode[i] = 1; m_nb[i] = 0; m_val[i] = 0; end
                1: begin
                    if (s) begin
                        m_err[i] = 1;
                        m_nb[i]  = v ? 1 : 0;
                        m_val[i] = v ? int'(b) : 0;
                    end else if (v) begin
                        m_val[i] = m_val[i] * 2 + int'(b);
                        m_nb[i]  = m_nb[i] + 1;
                        if (m_nb[i] == 3) begin
                            m_a[i]    = m_val[i];
                            m_cnt[i]  = (m_cnt[i] + 1) % (1 << fw[i]);
                            m_mode[i] = 2;
                            m_hold[i] = hc[i];
                            m_frames[i]++;
                            fe.a   = 3'(m_a[i]);
                            fe.cnt = 8'(m_cnt[i]);
                            fe.f   = majority(m_a[i]);
                            if (i == 0) fq0.push_back(fe); else fq1.push_back(fe);
                        end
                    end
                end
                default: begin
                    if (s || v) m_err[i] = 1;
                    m_hold[i] = m_hold[i] - 1;
                    if (m_hold[i] == 0) m_mode[i] = 0;
                end
            endcase
        end
        se.busy = (m_mode[i] != 0);
        se.en   = (m_mode[i] == 2);
        se.err  = (m_err[i] != 0);
        se.a    = 3'(m_a[i]);
        se.cnt  = 8'(m_cnt[i]);
        if (i == 0) sq0.push_back(se); else sq1.push_back(se);
    endtask

    task automatic cycle(input bit r, input bit s, input bit v, input bit b);
        @(negedge clk);
        rst = r;
        if0.start = s; if0.bit_vld = v; if0.bit_in = b;
        if1.start = s; if1.bit_vld = v; if1.bit_in = b;
        model_step(0, r, s, v, b);
        model_step(1, r, s, v, b);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cmp(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, i, got, exp, $time);
        end
    endtask

    task automatic check(input int i, input logic busy, input logic en, input logic err,
                         input logic [2:0] a, input logic [7:0] cnt);
        stat_t se;
        frm_t  fe;
        logic  f;
        if ((i == 0 && sq0.size() == 0) || (i == 1 && sq1.size() == 0)) return;
        if (i == 0) se = sq0.pop_front(); else se = sq1.pop_front();
        cmp("busy", i, 16'(busy), 16'(se.busy));
        cmp("en", i, 16'(en), 16'(se.en));
        cmp("err", i, 16'(err), 16'(se.err));
        cmp("a", i, 16'(a), 16'(se.a));
        cmp("frame_cnt", i, 16'(cnt), 16'(se.cnt));
        f = en & majority(int'(a));
        if (en && !prev_en[i]) begin
            pulses[i]++;
            if ((i == 0 && fq0.size() == 0) || (i == 1 && fq1.size() == 0)) begin
                cmp("unexpected_en", i, 16'(1), 16'(0));
            end else begin
                if (i == 0) fe = fq0.pop_front(); else fe = fq1.pop_front();
                cmp("frame_a", i, 16'(a), 16'(fe.a));
                cmp("frame_cnt_at_en", i, 16'(cnt), 16'(fe.cnt));
                cmp("voter_f", i, 16'(f), 16'(fe.f));
            end
        end
        if (en) begin
            run[i]++;
        end else if (prev_en[i]) begin
            cmp("en_len", i, 16'(run[i]), 16'(hc[i]));
            run[i] = 0;
        end
        prev_en[i] = en;
    endtask

    // Monitor: compare DUT outputs just after each active edge.
    always begin
        @(posedge clk);
        #1;
        check(0, if0.busy, if0.en, if0.err, if0.a, if0.frame_cnt);
        check(1, if1.busy, if1.en, if1.err, if1.a, 8'(if1.frame_cnt));
    end

    initial begin
        if0.start = 1'b0; if0.bit_vld = 1'b0; if0.bit_in = 1'b0;
        if1.start = 1'b0; if1.bit_vld = 1'b0; if1.bit_in = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Frame 1,0,1 back-to-back
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);
        // Frame 1,0,0 with two-cycle gaps
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        // Restart mid-frame with a simultaneous bit
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);
        // Frame 0,1,1 then a stray bit_vld
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        // Five frames after reset: counter wrap on the narrow instance
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int fr = 0; fr < 5; fr++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            idle(3);
        end
        idle(2);
        // Reset after two bits, then frame 1,1,0
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        // Random traffic; reset only outside a presentation window
        for (int n = 0; n < 3000; n++) begin
            bit r, s, v, b;
            r = ($urandom_range(0, 99) == 0) && (m_mode[0] != 2) && (m_mode[1] != 2);
            s = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 1) == 1);
            b = 1'($urandom_range(0, 1));
            cycle(r, s, v, b);
        end
        idle(8);
        @(posedge clk);
        #2;
        cmp("sq0_drained", 0, 16'(sq0.size()), 16'(0));
        cmp("sq1_drained", 1, 16'(sq1.size()), 16'(0));
        cmp("fq0_drained", 0, 16'(fq0.size()), 16'(0));
        cmp("fq1_drained", 1, 16'(fq1.size()), 16'(0));
        cmp("en_pulses", 0, 16'(pulses[0]), 16'(m_frames[0]));
        cmp("en_pulses", 1, 16'(pulses[1]), 16'(m_frames[1]));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule : tb_vote_frame_collector
